pipe_csel_adder: RTL and testbench
==================================

# pipe_csel_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready stream interface. It is the next generation of the team's 4-bit ripple-carry adder. Operands are split into BLK-bit slices, and each slice is resolved by a two-way carry-select (ripple sums for carry-in 0 and 1). One pipeline register sits per slice, so throughput is one operation per cycle at any WIDTH. It sits between operand-producing datapath logic and result consumers that may apply backpressure.

## Interface
- WIDTH, 16, operand/result width; must satisfy WIDTH % BLK == 0.
- BLK, 4, slice width in bits; NSL = WIDTH/BLK slices, NSL >= 1.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A (two's complement or unsigned).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A-B (B inverted, carry-in forced 1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB; for sub, 1 = no borrow (A >= B unsigned).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Stage k (k = 0..NSL-1) resolves slice k.
  - It computes s0/c0 and s1/c1 for slice k with carry-in 0 and 1.
  - It selects the pair using the carry registered from stage k-1. Stage 0 uses the effective carry-in: cin, or 1 when sub=1.
- Input skew:
  - Slice j operands (with b already conditionally inverted) are delayed j stages.
  - The result bits of slices already resolved travel with the beat.
  - At the output, all slices belong to the same beat.
- Last stage also registers ovf. The carry into the MSB is taken from inside the last slice's selected ripple chain.
- Per-stage valid bit v[k]; the output registers are stage NSL-1.
- Global advance enable: en = !out_valid | out_ready.
  - When en=1, every stage shifts one place: v[0] <= in_valid & in_ready.
  - When en=0, all stages hold data and valid.
- in_ready = en (combinational from out_valid and out_ready; no path from in_valid).
- Bubbles (v=0) propagate and are never presented on out_valid.
- sum/cout/ovf are held stable while out_valid=1 and out_ready=0.
- Reset (async assert, any time, including mid-stream):
  - All v[k] = 0 and all data registers = 0.
  - out_valid = 0, sum = 0, cout = 0, ovf = 0.
  - in_ready = 1 once reset is released.
  - In-flight beats are discarded and are not replayed.
- No FSM beyond the valid shift chain. The stall state is fully implied by out_valid & !out_ready.

## Timing
- Latency: a beat accepted at edge t (in_valid & in_ready) appears with out_valid=1 after edge t+NSL-1, i.e. NSL cycles from input to registered output. With NSL=1 the result is registered once.
- Throughput: 1 beat/cycle when out_ready is held high.
- Simultaneous out_ready=1 and in_valid=1 on a full pipe: the output beat retires and a new beat enters in the same cycle; nothing is lost or duplicated.
- Backpressure: out_ready low with out_valid high forces in_ready low in the same cycle.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Structure
- Package pipe_csel_pkg:
  - Function computing NSL from WIDTH/BLK.
  - Elaboration-time assertion that WIDTH % BLK == 0.
  - Typedef for the per-stage carry/valid record.
- Sub-module rca_block:
  - Parametrised BLK-bit ripple-carry adder built from full_adder cells.
  - Outputs sum, carry-out, and carry into its MSB (needed for ovf).
  - Instantiated twice per slice (cin 0/1).
- Top: generate loop over NSL stages, skew registers, valid chain, output mux.

## Test plan
- WIDTH=16, BLK=4, out_ready=1: a=0xFFFF, b=0x0001, cin=0, sub=0 → after 4 cycles sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, add → sum=0x8000, cout=0, ovf=1. With sub=1: a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1. a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0.
- Stream 100 random beats back-to-back with random sub/cin → results match the reference model in order, one per cycle after 4-cycle fill; no gaps.
- Hold out_ready=0 for 6 cycles with in_valid=1 continuously → in_ready drops once out_valid rises. Output is stable and no beat is lost or duplicated after out_ready returns.
- Assert rst_n=0 with 3 beats in flight → out_valid=0 and sum/cout/ovf=0 immediately (asynchronously). After release, in_ready=1 and no stale beat emerges.
- Re-run the add/sub scenarios at WIDTH=8, BLK=8 (NSL=1, latency 1) and WIDTH=32, BLK=4 (latency 8); results and latency match the model.

Source files
------------

// File: rtl/pipe_csel_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-select adder.
// Slice count and configuration legality are derived here so every file agrees.
package pipe_csel_pkg;

    // Per-stage control record: beat valid plus the slice carry it hands on.
    typedef struct packed {
        logic v;
        logic c;
    } stage_ctl_t;

    function automatic int calc_nsl(input int width, input int blk);
        return (blk > 0) ? (width / blk) : 0;
    endfunction

    function automatic bit csel_cfg_ok(input int width, input int blk);
        return (blk > 0) && (width >= blk) && ((width % blk) == 0);
    endfunction

endpackage

// File: rtl/pipe_csel_adder_if.sv
// Operand/result stream bundle for pipe_csel_adder.
// The producer/consumer side uses master, the adder uses slave.
interface pipe_csel_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_csel_adder_rca_block.sv
// BLK-bit ripple-carry adder built from full_adder cells; also exposes the
// carry into its MSB so the last slice can form signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           cmsb
);
    logic [BLK:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < BLK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c_s[i]),
            .sum  (sum[i]),
            .cout (c_s[i+1])
        );
    end

    assign cout = c_s[BLK];
    assign cmsb = c_s[BLK-1];
endmodule

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor: one register stage per BLK-bit slice,
// operands skewed so slice k is resolved in stage k, stream handshake on both sides.
module pipe_csel_adder
    import pipe_csel_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_csel_adder_if.slave  bus
);
    localparam int NSL = calc_nsl(WIDTH, BLK);

    if (!csel_cfg_ok(WIDTH, BLK)) begin : g_bad_cfg
        $error("pipe_csel_adder: WIDTH must be a positive multiple of BLK");
    end

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;

    // Stage registers; operand copies are pre-shifted so the next slice sits at bit 0.
    stage_ctl_t       ctl_r [NSL];
    logic [WIDTH-1:0] res_r [NSL];
    logic [WIDTH-1:0] opa_r [NSL];
    logic [WIDTH-1:0] opb_r [NSL];
    logic             ovf_r;

    logic [WIDTH-1:0] opa_in_s  [NSL];
    logic [WIDTH-1:0] opb_in_s  [NSL];
    logic [WIDTH-1:0] res_in_s  [NSL];
    logic [WIDTH-1:0] res_nxt_s [NSL];
    logic             c_in_s    [NSL];
    logic             c_nxt_s   [NSL];
    logic             v_in_s    [NSL];
    logic             ovf_nxt_s;

    assign en_s      = !ctl_r[NSL-1].v | bus.out_ready;
    assign b_eff_s   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff_s = bus.sub ? 1'b1 : bus.cin;

    for (genvar k = 0; k < NSL; k++) begin : g_stage
        logic [BLK-1:0]   s0_s;
        logic [BLK-1:0]   s1_s;
        logic             c0_s;
        logic             c1_s;
        logic             m0_s;
        logic             m1_s;
        logic [BLK-1:0]   sel_s;
        logic [WIDTH-1:0] slice_s;

        if (k == 0) begin : g_first
            assign opa_in_s[k] = bus.a;
            assign opb_in_s[k] = b_eff_s;
            assign c_in_s[k]   = cin_eff_s;
            assign res_in_s[k] = {WIDTH{1'b0}};
            assign v_in_s[k]   = bus.in_valid & en_s;
        end else begin : g_next
            assign opa_in_s[k] = opa_r[k-1];
            assign opb_in_s[k] = opb_r[k-1];
            assign c_in_s[k]   = ctl_r[k-1].c;
            assign res_in_s[k] = res_r[k-1];
            assign v_in_s[k]   = ctl_r[k-1].v;
        end

        rca_block #(.BLK(BLK)) u_rca0 (
            .a    (opa_in_s[k][BLK-1:0]),
            .b    (opb_in_s[k][BLK-1:0]),
            .cin  (1'b0),
            .sum  (s0_s),
            .cout (c0_s),
            .cmsb (m0_s)
        );

        rca_block #(.BLK(BLK)) u_rca1 (
            .a    (opa_in_s[k][BLK-1:0]),
            .b    (opb_in_s[k][BLK-1:0]),
            .cin  (1'b1),
            .sum  (s1_s),
            .cout (c1_s),
            .cmsb (m1_s)
        );

        // The incoming carry picks between the two precomputed slice results.
        assign sel_s        = c_in_s[k] ? s1_s : s0_s;
        assign c_nxt_s[k]   = c_in_s[k] ? c1_s : c0_s;
        assign slice_s      = WIDTH'(sel_s);
        assign res_nxt_s[k] = res_in_s[k] | (slice_s << (k * BLK));

        if (k == NSL - 1) begin : g_last
            assign ovf_nxt_s = (c_in_s[k] ? m1_s : m0_s) ^ c_nxt_s[k];
        end
    end

    // Whole pipe advances together; a stalled output freezes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSL; k++) begin
                ctl_r[k] <= '{v: 1'b0, c: 1'b0};
                res_r[k] <= {WIDTH{1'b0}};
                opa_r[k] <= {WIDTH{1'b0}};
                opb_r[k] <= {WIDTH{1'b0}};
            end
            ovf_r <= 1'b0;
        end else if (en_s) begin
            for (int k = 0; k < NSL; k++) begin
                ctl_r[k] <= '{v: v_in_s[k], c: c_nxt_s[k]};
                res_r[k] <= res_nxt_s[k];
                opa_r[k] <= opa_in_s[k] >> BLK;
                opb_r[k] <= opb_in_s[k] >> BLK;
            end
            ovf_r <= ovf_nxt_s;
        end
    end

    assign bus.in_ready  = en_s;
    assign bus.out_valid = ctl_r[NSL-1].v;
    assign bus.sum       = res_r[NSL-1];
    assign bus.cout      = ctl_r[NSL-1].c;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_pipe_csel_adder.sv
// Self-checking bench for pipe_csel_adder at 16/4, 8/8 and 32/4 against an
// arithmetic reference model with an in-order scoreboard on the 16-bit instance.
module tb_pipe_csel_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_csel_adder_if #(.WIDTH(16)) bus16 ();
    pipe_csel_adder_if #(.WIDTH(8))  bus8  ();
    pipe_csel_adder_if #(.WIDTH(32)) bus32 ();

    pipe_csel_adder #(.WIDTH(16), .BLK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    pipe_csel_adder #(.WIDTH(8),  .BLK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    pipe_csel_adder #(.WIDTH(32), .BLK(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    int n_checks = 0;
    int n_fail   = 0;
    logic [33:0] exp_q [$];

    // {ovf, cout, sum} of a w-bit add/subtract computed with plain integer arithmetic.
    function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic ci, input logic s, input int w);
        longint unsigned mask, av, bv, cv, tot;
        logic [31:0] sm;
        logic co, ov, sa, sb, ss;
        mask = (64'd1 << w) - 64'd1;
        av   = {32'd0, a} & mask;
        bv   = (s ? {32'd0, ~b} : {32'd0, b}) & mask;
        cv   = s ? 64'd1 : {63'd0, ci};
        tot  = av + bv + cv;
        sm   = 32'(tot & mask);
        co   = tot[w];
        sa   = av[w-1];
        sb   = bv[w-1];
        ss   = tot[w-1];
        ov   = (sa == sb) && (ss != sa);
        return {ov, co, sm};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle of the 16-bit stream: score handshakes, then advance to the next negedge.
    task automatic tick16();
        logic [33:0] e;
        logic [33:0] got;
        #1;
        if (bus16.out_valid && bus16.out_ready) begin
            check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus16.ovf, bus16.cout, 16'h0000, bus16.sum};
                check("scoreboard16", 64'(got), 64'(e));
            end
        end
        if (bus16.in_valid && bus16.in_ready) begin
            e = ref_model({16'h0000, bus16.a}, {16'h0000, bus16.b}, bus16.cin, bus16.sub, 16);
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic s, input logic [15:0] es, input logic ec, input logic eo);
        int n;
        bus16.a = a; bus16.b = b; bus16.cin = ci; bus16.sub = s;
        bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
        tick16();
        bus16.in_valid = 1'b0;
        n = 1;
        while (!bus16.out_valid && n < 40) begin
            tick16();
            n++;
        end
        check("lat16", 64'(n), 64'd4);
        check("sum16", 64'(bus16.sum), 64'(es));
        check("cout16", 64'(bus16.cout), 64'(ec));
        check("ovf16", 64'(bus16.ovf), 64'(eo));
        tick16();
        check("idle16", 64'(bus16.out_valid), 64'd0);
    endtask

    // Single beat on the 8- or 32-bit instance with latency and result checks.
    task automatic send_w(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic s, input logic [33:0] e);
        int n;
        logic ov, rdy;
        logic [33:0] got;
        if (w == 8) begin
            bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = ci; bus8.sub = s; bus8.in_valid = 1'b1;
        end else begin
            bus32.a = a; bus32.b = b; bus32.cin = ci; bus32.sub = s; bus32.in_valid = 1'b1;
        end
        #1;
        rdy = (w == 8) ? bus8.in_ready : bus32.in_ready;
        check("rdy_w", 64'(rdy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
        n  = 1;
        ov = (w == 8) ? bus8.out_valid : bus32.out_valid;
        while (!ov && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            ov = (w == 8) ? bus8.out_valid : bus32.out_valid;
        end
        got = (w == 8) ? {bus8.ovf, bus8.cout, 24'h000000, bus8.sum}
                       : {bus32.ovf, bus32.cout, bus32.sum};
        check((w == 8) ? "lat8" : "lat32", 64'(n), (w == 8) ? 64'd1 : 64'd8);
        check((w == 8) ? "res8" : "res32", 64'(got), 64'(e));
        @(posedge clk);
        @(negedge clk);
        ov = (w == 8) ? bus8.out_valid : bus32.out_valid;
        check("idle_w", 64'(ov), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [33:0] held;
        logic [31:0] ra, rb;
        logic        rc, rs;
        int          n;

        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.sub  = 1'b0; bus8.out_ready  = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;

        #2;
        check("rst_out_valid", 64'(bus16.out_valid), 64'd0);
        check("rst_sum", 64'(bus16.sum), 64'd0);
        check("rst_cout", 64'(bus16.cout), 64'd0);
        check("rst_ovf", 64'(bus16.ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus16.in_ready), 64'd1);
        @(negedge clk);

        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send16(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);

        // Back-to-back random stream: no gaps once the pipe is full.
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 103; i++) begin
            bus16.in_valid = (i < 100);
            bus16.a = 16'($urandom); bus16.b = 16'($urandom);
            bus16.cin = 1'($urandom); bus16.sub = 1'($urandom);
            tick16();
            if (i >= 3) check("stream_nogap", 64'(bus16.out_valid), 64'd1);
        end
        bus16.in_valid = 1'b0;
        tick16();
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: consumer stalls six cycles while the producer keeps offering.
        held = '0;
        for (int i = 0; i < 12; i++) begin
            bus16.in_valid = 1'b1;
            bus16.out_ready = (i >= 6);
            bus16.a = 16'($urandom); bus16.b = 16'($urandom);
            bus16.cin = 1'($urandom); bus16.sub = 1'($urandom);
            tick16();
            if (i == 3) held = {bus16.ovf, bus16.cout, 16'h0000, bus16.sum};
            if (i >= 3 && i <= 5) begin
                check("stall_out_valid", 64'(bus16.out_valid), 64'd1);
                check("stall_in_ready", 64'(bus16.in_ready), 64'd0);
                check("stall_hold", 64'({bus16.ovf, bus16.cout, 16'h0000, bus16.sum}), 64'(held));
            end
        end
        bus16.in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 30) begin
            tick16();
            n++;
        end
        check("stall_drained", 64'(exp_q.size()), 64'd0);
        tick16();
        check("stall_no_dup", 64'(bus16.out_valid), 64'd0);

        // Asynchronous reset with beats in flight.
        bus16.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus16.in_valid = 1'b1;
            bus16.a = 16'($urandom) | 16'h0101; bus16.b = 16'($urandom);
            bus16.cin = 1'($urandom); bus16.sub = 1'b0;
            tick16();
        end
        bus16.in_valid = 1'b0;
        check("pre_rst_valid", 64'(bus16.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus16.out_valid), 64'd0);
        check("arst_sum", 64'(bus16.sum), 64'd0);
        check("arst_cout", 64'(bus16.cout), 64'd0);
        check("arst_ovf", 64'(bus16.ovf), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus16.out_ready = 1'b1;
        #1;
        check("post_rst_ready", 64'(bus16.in_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick16();
            check("no_stale_beat", 64'(bus16.out_valid), 64'd0);
        end

        // Other geometries: NSL=1 and NSL=8.
        send_w(8, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00000000});
        send_w(8, 32'h0000007F, 32'h00000001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h00000080});
        send_w(8, 32'h00000080, 32'h00000001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h0000007F});
        send_w(8, 32'h00000005, 32'h00000007, 1'b0, 1'b1, {1'b0, 1'b0, 32'h000000FE});
        send_w(32, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00000000});
        send_w(32, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h80000000});
        send_w(32, 32'h80000000, 32'h00000001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFFFFFF});
        send_w(32, 32'h00000005, 32'h00000007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFE});
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            send_w(8, {24'h000000, ra[7:0]}, {24'h000000, rb[7:0]}, rc, rs,
                   ref_model({24'h000000, ra[7:0]}, {24'h000000, rb[7:0]}, rc, rs, 8));
            send_w(32, ra, rb, rc, rs, ref_model(ra, rb, rc, rs, 32));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
